jk_count_sequencer: RTL and testbench

Run/stop/load controller for a JK-flip-flop counter register. Each cycle it computes the J/K excitation for a WIDTH-bit bank of JK stages. It supports up, down and hold modes, a programmable terminal value, and continuous or one-shot operation. It sits between a command source (control FSM or register interface) and the JK counter datapath, and exposes the excitation vectors for observability.

---
 rtl/jk_seq_pkg.sv | 15 +
 rtl/jk_count_sequencer_jk_stage.sv | 27 ++
 rtl/jk_count_sequencer.sv | 130 +++++++++++++
 tb/tb_jk_count_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/jk_seq_pkg.sv
// Shared types and command encodings for the JK counter sequencer.
package jk_seq_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN_UP   = 2'd1,
      RUN_DOWN = 2'd2
   } state_e;

   localparam logic [1:0] OP_STOP     = 2'b00;
   localparam logic [1:0] OP_RUN_UP   = 2'b01;
   localparam logic [1:0] OP_RUN_DOWN = 2'b10;
   localparam logic [1:0] OP_LOAD     = 2'b11;

endpackage

// File: rtl/jk_count_sequencer_jk_stage.sv
// One JK flip-flop bit: 00 hold, 01 clear, 10 set, 11 toggle.
module jk_stage (
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);

   logic q_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q_q <= 1'b0;
            2'b10:   q_q <= 1'b1;
            2'b11:   q_q <= ~q_q;
            default: q_q <= q_q;
         endcase
      end
   end

   assign q = q_q;

endmodule

// File: rtl/jk_count_sequencer.sv
// Run/stop/load controller computing J/K excitation for a bank of JK stages.
module jk_count_sequencer
   import jk_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_oneshot,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] j_vec,
   output logic [WIDTH-1:0] k_vec,
   output logic             busy,
   output logic             tc
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] limit_q, limit_d;
   logic             oneshot_q, oneshot_d;
   logic             tc_q, tc_d;
   logic             busy_q, busy_d;
   logic             ready_q;

   logic [WIDTH-1:0] count_w;
   logic [WIDTH-1:0] next_val;
   logic [WIDTH-1:0] target;
   logic             accept;
   logic             advance;
   logic             wrap;
   logic             hold_stop;
   logic             excite;

   assign accept = cmd_valid & ready_q;
   assign advance = (state_q != IDLE) & tick & ~accept;

   always_comb begin
      next_val = count_w;
      wrap     = 1'b0;
      if (state_q == RUN_DOWN) begin
         wrap     = (count_w == '0);
         next_val = wrap ? limit_q : count_w - ONE;
      end else begin
         wrap     = (count_w >= limit_q);
         next_val = wrap ? '0 : count_w + ONE;
      end
   end

   // A oneshot wrap freezes the count; the stop is signalled via state and tc only.
   assign hold_stop = advance & wrap & oneshot_q;

   always_comb begin
      target = next_val;
      excite = advance & ~hold_stop;
      if (accept && cmd_op == OP_LOAD) begin
         target = cmd_data;
         excite = 1'b1;
      end
   end

   assign j_vec = excite ? (target & ~count_w) : '0;
   assign k_vec = excite ? (~target & count_w) : '0;

   always_comb begin
      state_d   = state_q;
      limit_d   = limit_q;
      oneshot_d = oneshot_q;
      if (accept) begin
         case (cmd_op)
            OP_STOP: state_d = IDLE;
            OP_RUN_UP: begin
               state_d   = RUN_UP;
               limit_d   = cmd_data;
               oneshot_d = cmd_oneshot;
            end
            OP_RUN_DOWN: begin
               state_d   = RUN_DOWN;
               limit_d   = cmd_data;
               oneshot_d = cmd_oneshot;
            end
            default: state_d = state_q;
         endcase
      end else if (hold_stop) begin
         state_d = IDLE;
      end
   end

   assign tc_d   = advance & wrap;
   assign busy_d = (state_d != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         limit_q   <= '1;
         oneshot_q <= 1'b0;
         tc_q      <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         limit_q   <= limit_d;
         oneshot_q <= oneshot_d;
         tc_q      <= tc_d;
         busy_q    <= busy_d;
         ready_q   <= 1'b1;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      jk_stage u_stage (
         .clk (clk),
         .rst (rst),
         .j   (j_vec[i]),
         .k   (k_vec[i]),
         .q   (count_w[i])
      );
   end

   assign count     = count_w;
   assign cmd_ready = ready_q;
   assign busy      = busy_q;
   assign tc        = tc_q;

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Directed scoreboard bench for jk_count_sequencer (WIDTH=3).
module tb_jk_count_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [2:0] cmd_data = 3'd0;
   logic       cmd_oneshot = 1'b0;
   logic [2:0] count, j_vec, k_vec;
   logic       busy, tc;

   int n_chk = 0;
   int n_fail = 0;
   int n_rec = 0;

   typedef struct {
      int         idx;
      logic [2:0] count;
      logic [2:0] j;
      logic [2:0] k;
      logic       busy;
      logic       tc;
      logic       rdy;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   always #5 clk = ~clk;

   jk_count_sequencer #(.WIDTH(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_data    (cmd_data),
      .cmd_oneshot (cmd_oneshot),
      .count       (count),
      .j_vec       (j_vec),
      .k_vec       (k_vec),
      .busy        (busy),
      .tc          (tc)
   );

   task automatic chk(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s rec%0d: got %0b expected %0b", name, idx, act, exp);
      end
   endtask

   // Monitor: outputs are presented once per cycle and sampled on the falling edge.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("count", e.idx, count, e.count);
         chk("j_vec", e.idx, j_vec, e.j);
         chk("k_vec", e.idx, k_vec, e.k);
         chk("busy", e.idx, {2'b0, busy}, {2'b0, e.busy});
         chk("tc", e.idx, {2'b0, tc}, {2'b0, e.tc});
         chk("cmd_ready", e.idx, {2'b0, cmd_ready}, {2'b0, e.rdy});
      end
   end

   task automatic step(input logic r, input logic t, input logic v, input logic [1:0] op,
                       input logic [2:0] d, input logic os,
                       input logic [2:0] ec, input logic eb, input logic etc,
                       input logic [2:0] ej, input logic [2:0] ek, input logic er);
      exp_t x;
      @(posedge clk);
      #1;
      tick = t; cmd_valid = v; cmd_op = op; cmd_data = d; cmd_oneshot = os;
      rst = r;
      x.idx = n_rec; x.count = ec; x.j = ej; x.k = ek; x.busy = eb; x.tc = etc; x.rdy = er;
      sb.push_back(x);
      n_rec++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //   r  t  v  op     d     os  count b  tc j      k      rdy
      step(1, 0, 0, 2'b00, 3'd0, 0, 3'd0, 0, 0, 3'b000, 3'b000, 0);
      step(0, 0, 0, 2'b00, 3'd0, 0, 3'd0, 0, 0, 3'b000, 3'b000, 0);
      // RUN_UP limit 5 continuous; tick with the command is ignored
      step(0, 1, 1, 2'b01, 3'd5, 0, 3'd0, 0, 0, 3'b000, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd0, 1, 0, 3'b001, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd1, 1, 0, 3'b010, 3'b001, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd2, 1, 0, 3'b001, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd3, 1, 0, 3'b100, 3'b011, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd4, 1, 0, 3'b001, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd5, 1, 0, 3'b000, 3'b101, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd0, 1, 1, 3'b001, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd1, 1, 0, 3'b010, 3'b001, 1);
      // LOAD 6 with a tick, then RUN_DOWN limit 6 oneshot
      step(0, 1, 1, 2'b11, 3'd6, 0, 3'd2, 1, 0, 3'b100, 3'b000, 1);
      step(0, 0, 1, 2'b10, 3'd6, 1, 3'd6, 1, 0, 3'b000, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd6, 1, 0, 3'b001, 3'b010, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd5, 1, 0, 3'b000, 3'b001, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd4, 1, 0, 3'b011, 3'b100, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd3, 1, 0, 3'b000, 3'b001, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd2, 1, 0, 3'b001, 3'b010, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd1, 1, 0, 3'b000, 3'b001, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd0, 1, 0, 3'b000, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd0, 0, 1, 3'b000, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd0, 0, 0, 3'b000, 3'b000, 1);
      // RUN_UP limit 7, tick toggling, then 7->0 wrap
      step(0, 0, 1, 2'b01, 3'd7, 0, 3'd0, 0, 0, 3'b000, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd0, 1, 0, 3'b001, 3'b000, 1);
      step(0, 0, 0, 2'b00, 3'd0, 0, 3'd1, 1, 0, 3'b000, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd1, 1, 0, 3'b010, 3'b001, 1);
      step(0, 0, 0, 2'b00, 3'd0, 0, 3'd2, 1, 0, 3'b000, 3'b000, 1);
      step(0, 0, 1, 2'b11, 3'd7, 0, 3'd2, 1, 0, 3'b101, 3'b000, 1);
      step(0, 0, 0, 2'b00, 3'd0, 0, 3'd7, 1, 0, 3'b000, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd7, 1, 0, 3'b000, 3'b111, 1);
      step(0, 0, 0, 2'b00, 3'd0, 0, 3'd0, 1, 1, 3'b000, 3'b000, 1);
      step(0, 0, 0, 2'b00, 3'd0, 0, 3'd0, 1, 0, 3'b000, 3'b000, 1);
      // count 6 above limit 3 wraps to 0; STOP together with a tick
      step(0, 0, 1, 2'b11, 3'd6, 0, 3'd0, 1, 0, 3'b110, 3'b000, 1);
      step(0, 0, 1, 2'b01, 3'd3, 0, 3'd6, 1, 0, 3'b000, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd6, 1, 0, 3'b000, 3'b110, 1);
      step(0, 1, 1, 2'b00, 3'd0, 0, 3'd0, 1, 1, 3'b000, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd0, 0, 0, 3'b000, 3'b000, 1);
      // continuous RUN_UP limit 0
      step(0, 1, 1, 2'b01, 3'd0, 0, 3'd0, 0, 0, 3'b000, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd0, 1, 0, 3'b000, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd0, 1, 1, 3'b000, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd0, 1, 1, 3'b000, 3'b000, 1);
      step(0, 0, 0, 2'b00, 3'd0, 0, 3'd0, 1, 1, 3'b000, 3'b000, 1);
      step(0, 0, 0, 2'b00, 3'd0, 0, 3'd0, 1, 0, 3'b000, 3'b000, 1);
      // RUN_UP limit 7, reset asserted mid-cycle with count 2
      step(0, 0, 1, 2'b01, 3'd7, 0, 3'd0, 1, 0, 3'b000, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd0, 1, 0, 3'b001, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd1, 1, 0, 3'b010, 3'b001, 1);
      step(1, 1, 0, 2'b00, 3'd0, 0, 3'd0, 0, 0, 3'b000, 3'b000, 0);
      step(1, 1, 0, 2'b00, 3'd0, 0, 3'd0, 0, 0, 3'b000, 3'b000, 0);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd0, 0, 0, 3'b000, 3'b000, 0);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd0, 0, 0, 3'b000, 3'b000, 1);
      step(0, 1, 0, 2'b00, 3'd0, 0, 3'd0, 0, 0, 3'b000, 3'b000, 1);

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
